// File: rtl/serial_fa_if.sv
// serial_fa_if: start/done operand and result bundle for the bit-serial adder
interface serial_fa_if #(parameter int WIDTH = 8);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  modport master (output start, sub, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave (input start, sub, a, b, cin, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/serial_fa_seq.sv
// serial_fa_seq: LSB-first bit-serial add/subtract through a single full-adder cell
module serial_fa_seq #(
  parameter int WIDTH = 8
) (
  input logic        clk,
  input logic        rst,
  serial_fa_if.slave io
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic             s, co, last;
  // subtraction is a + ~b + 1: invert b at capture and seed the carry with 1
  always_comb begin
    s       = a_q[0] ^ b_q[0] ^ carry_q;
    co      = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
    last    = cnt_q == CNT_W'(WIDTH - 1);
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (io.start) begin
        state_d = RUN;
        a_d     = io.a;
        b_d     = io.sub ? ~io.b : io.b;
        carry_d = io.sub | io.cin;
        cnt_d   = '0;
      end
      RUN: begin
        sum_d   = {s, sum_q[WIDTH-1:1]};
        carry_d = co;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last) begin
          cout_d  = co;
          ovf_d   = carry_q ^ co;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
  assign io.busy = state_q == RUN;
  assign io.done = state_q == DONE;
  assign io.sum  = sum_q;
  assign io.cout = cout_q;
  assign io.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_fa_seq.sv
// tb_serial_fa_seq: table vectors, handshake corner cases and random sweep with a result scoreboard
module tb_serial_fa_seq;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  serial_fa_if #(.WIDTH(W)) io();
  serial_fa_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .io(io));
  always #5 clk = ~clk;
  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } res_t;
  typedef struct {
    logic         sub;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    res_t         e;
  } vec_t;
  res_t q[$];
  res_t pe;
  vec_t tbl[8];
  int n_cmp = 0, n_err = 0, n_acc = 0, n_done = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic res_t model(input logic sub, input logic cin, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] r;
    res_t o;
    if (sub) begin
      r    = {1'b0, a} - {1'b0, b};
      o.co = ~r[W];
      o.ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    end else begin
      r    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      o.co = r[W];
      o.ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    end
    o.s = r[W-1:0];
    return o;
  endfunction
  always @(negedge clk) begin
    if (!rst && io.done) begin
      n_done++;
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no pending result at %0t", $time);
      end else begin
        pe = q.pop_front();
        chk("sum", io.sum, pe.s);
        chk("cout", io.cout, pe.co);
        chk("ovf", io.ovf, pe.ov);
      end
    end
  end
  task automatic wait_done(output int k, output int busy_n);
    k = 0;
    busy_n = 0;
    do begin
      @(negedge clk);
      k++;
      if (io.busy) busy_n++;
    end while (!io.done && k < 4 * W);
    if (!io.done) chk("done_timeout", 0, 1);
  endtask
  task automatic run_op(input logic sub, input logic cin, input logic [W-1:0] a, input logic [W-1:0] b, input res_t e);
    int k, busy_n;
    @(negedge clk);
    io.start = 1'b1;
    io.sub = sub;
    io.cin = cin;
    io.a = a;
    io.b = b;
    q.push_back(e);
    n_acc++;
    @(posedge clk);
    #1 io.start = 1'b0;
    wait_done(k, busy_n);
    chk("done_latency", k, W + 1);
    chk("busy_cycles", busy_n, W);
  endtask
  initial begin
    int k, busy_n;
    logic s, c;
    logic [W-1:0] ra, rb;
    io.start = 1'b0;
    io.sub = 1'b0;
    io.cin = 1'b0;
    io.a = '0;
    io.b = '0;
    tbl[0] = '{1'b0, 1'b0, 8'h3C, 8'h0F, '{8'h4B, 1'b0, 1'b0}};
    tbl[1] = '{1'b0, 1'b0, 8'hFF, 8'h01, '{8'h00, 1'b1, 1'b0}};
    tbl[2] = '{1'b0, 1'b0, 8'h7F, 8'h01, '{8'h80, 1'b0, 1'b1}};
    tbl[3] = '{1'b0, 1'b1, 8'h00, 8'h00, '{8'h01, 1'b0, 1'b0}};
    tbl[4] = '{1'b1, 1'b0, 8'h05, 8'h07, '{8'hFE, 1'b0, 1'b0}};
    tbl[5] = '{1'b1, 1'b0, 8'h80, 8'h01, '{8'h7F, 1'b1, 1'b1}};
    tbl[6] = '{1'b1, 1'b1, 8'h05, 8'h07, '{8'hFE, 1'b0, 1'b0}};
    tbl[7] = '{1'b0, 1'b1, 8'hFF, 8'hFF, '{8'hFF, 1'b1, 1'b0}};
    #1 rst = 1'b1;
    #1;
    chk("rst_busy", io.busy, 0);
    chk("rst_done", io.done, 0);
    chk("rst_sum", io.sum, 0);
    chk("rst_cout", io.cout, 0);
    chk("rst_ovf", io.ovf, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    foreach (tbl[i]) run_op(tbl[i].sub, tbl[i].cin, tbl[i].a, tbl[i].b, tbl[i].e);
    @(negedge clk);
    chk("done_one_cycle", io.done, 0);
    chk("idle_after_done", io.busy, 0);
    io.start = 1'b1;
    io.sub = 1'b0;
    io.cin = 1'b0;
    io.a = 8'h10;
    io.b = 8'h20;
    q.push_back('{8'h30, 1'b0, 1'b0});
    n_acc++;
    k = 0;
    forever begin
      @(negedge clk);
      k++;
      if (io.done || k > 4 * W) break;
      io.a = W'($urandom);
      io.b = W'($urandom);
      io.sub = 1'($urandom);
      io.cin = 1'($urandom);
    end
    chk("hold_done_seen", io.done, 1);
    chk("hold_latency", k, W + 1);
    io.sub = 1'b0;
    io.cin = 1'b0;
    io.a = 8'h01;
    io.b = 8'h02;
    @(negedge clk);
    chk("start_in_done_ignored", io.busy, 0);
    chk("single_done_pulse", io.done, 0);
    @(negedge clk);
    chk("restart_from_idle", io.busy, 1);
    q.push_back('{8'h03, 1'b0, 1'b0});
    n_acc++;
    io.start = 1'b0;
    wait_done(k, busy_n);
    chk("restart_latency", k, W);
    @(negedge clk);
    io.start = 1'b1;
    io.a = 8'h12;
    io.b = 8'h34;
    @(posedge clk);
    #1 io.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", io.busy, 0);
    chk("mid_rst_done", io.done, 0);
    chk("mid_rst_sum", io.sum, 0);
    chk("mid_rst_cout", io.cout, 0);
    chk("mid_rst_ovf", io.ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    run_op(1'b0, 1'b0, 8'hAA, 8'h55, '{8'hFF, 1'b0, 1'b0});
    for (int i = 0; i < 500; i++) begin
      s = 1'($urandom);
      c = 1'($urandom);
      ra = W'($urandom);
      rb = W'($urandom);
      run_op(s, c, ra, rb, model(s, c, ra, rb));
    end
    repeat (3) @(negedge clk);
    chk("done_count", n_done, n_acc);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
